// File: rtl/alu_control_pipe_pkg.sv
// Shared encodings for the registered ALU control decoder: select codes,
// RV32I opcode/funct7 constants, FSM states and small decode helpers.
package alu_control_pipe_pkg;

  localparam int kALU_OP_SEL_WIDTH     = 5;
  localparam int kALU_BRANCH_SEL_WIDTH = 3;

  // ALU op select codes; 0 is reserved as the post-reset value
  localparam logic [4:0] kSAIL_ALUCTL_6to0_ADD     = 5'd1;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_SUB     = 5'd2;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_SLL     = 5'd3;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_SLT     = 5'd4;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_SLTU    = 5'd5;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_XOR     = 5'd6;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_SRL     = 5'd7;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_SRA     = 5'd8;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_OR      = 5'd9;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_AND     = 5'd10;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_BRANCH  = 5'd11;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_ILLEGAL = 5'd12;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_MUL     = 5'd13;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_MULH    = 5'd14;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_MULHSU  = 5'd15;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_MULHU   = 5'd16;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_DIV     = 5'd17;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_DIVU    = 5'd18;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_REM     = 5'd19;
  localparam logic [4:0] kSAIL_ALUCTL_6to0_REMU    = 5'd20;

  // Branch comparator selects; 0 means "not a branch"
  localparam logic [2:0] kBR_NONE = 3'd0;
  localparam logic [2:0] kBR_BEQ  = 3'd1;
  localparam logic [2:0] kBR_BNE  = 3'd2;
  localparam logic [2:0] kBR_BLT  = 3'd3;
  localparam logic [2:0] kBR_BGE  = 3'd4;
  localparam logic [2:0] kBR_BLTU = 3'd5;
  localparam logic [2:0] kBR_BGEU = 3'd6;

  localparam logic [6:0] kRV32I_OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] kRV32I_OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] kRV32I_OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] kRV32I_OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] kRV32I_OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] kRV32I_OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] kRV32I_OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] kRV32I_OPCODE_IMMOP  = 7'b0010011;
  localparam logic [6:0] kRV32I_OPCODE_ALUOP  = 7'b0110011;

  localparam logic [6:0] kRV32I_FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] kRV32I_FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] kRV32I_FUNCT7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_MC_WAIT = 2'd2
  } state_e;

  // Base (funct7 = 0) register/immediate op for a given funct3
  function automatic logic [4:0] base_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  base_op = kSAIL_ALUCTL_6to0_ADD;
      3'b001:  base_op = kSAIL_ALUCTL_6to0_SLL;
      3'b010:  base_op = kSAIL_ALUCTL_6to0_SLT;
      3'b011:  base_op = kSAIL_ALUCTL_6to0_SLTU;
      3'b100:  base_op = kSAIL_ALUCTL_6to0_XOR;
      3'b101:  base_op = kSAIL_ALUCTL_6to0_SRL;
      3'b110:  base_op = kSAIL_ALUCTL_6to0_OR;
      default: base_op = kSAIL_ALUCTL_6to0_AND;
    endcase
  endfunction

  // RV32M op for a given funct3
  function automatic logic [4:0] m_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  m_op = kSAIL_ALUCTL_6to0_MUL;
      3'b001:  m_op = kSAIL_ALUCTL_6to0_MULH;
      3'b010:  m_op = kSAIL_ALUCTL_6to0_MULHSU;
      3'b011:  m_op = kSAIL_ALUCTL_6to0_MULHU;
      3'b100:  m_op = kSAIL_ALUCTL_6to0_DIV;
      3'b101:  m_op = kSAIL_ALUCTL_6to0_DIVU;
      3'b110:  m_op = kSAIL_ALUCTL_6to0_REM;
      default: m_op = kSAIL_ALUCTL_6to0_REMU;
    endcase
  endfunction

endpackage

// File: rtl/alu_control_pipe_decode.sv
// Pure combinational RV32I(+M) ALU control decoder with legality checking.
module alu_decode_comb
  import alu_control_pipe_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic [6:0]                       opcode,
  input  logic [2:0]                       funct3,
  input  logic [6:0]                       funct7,
  output logic [kALU_OP_SEL_WIDTH-1:0]     op_sel,
  output logic [kALU_BRANCH_SEL_WIDTH-1:0] branch_sel,
  output logic                             illegal,
  output logic                             is_mul,
  output logic                             is_div
);

  // Default every encoding to illegal; legal cases override
  always_comb begin
    op_sel     = kSAIL_ALUCTL_6to0_ILLEGAL;
    branch_sel = kBR_NONE;
    illegal    = 1'b1;
    is_mul     = 1'b0;
    is_div     = 1'b0;
    case (opcode)
      kRV32I_OPCODE_LUI: begin
        op_sel  = kSAIL_ALUCTL_6to0_AND;
        illegal = 1'b0;
      end
      kRV32I_OPCODE_AUIPC: begin
        op_sel  = kSAIL_ALUCTL_6to0_ADD;
        illegal = 1'b0;
      end
      kRV32I_OPCODE_LOAD: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          op_sel  = kSAIL_ALUCTL_6to0_ADD;
          illegal = 1'b0;
        end
      end
      kRV32I_OPCODE_STORE: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
          op_sel  = kSAIL_ALUCTL_6to0_ADD;
          illegal = 1'b0;
        end
      end
      // Jumps keep the ILLEGAL select (no ALU work) but are legal instructions
      kRV32I_OPCODE_JAL, kRV32I_OPCODE_JALR: begin
        illegal = 1'b0;
      end
      kRV32I_OPCODE_BRANCH: begin
        illegal = 1'b0;
        op_sel  = kSAIL_ALUCTL_6to0_BRANCH;
        case (funct3)
          3'b000: branch_sel = kBR_BEQ;
          3'b001: branch_sel = kBR_BNE;
          3'b100: branch_sel = kBR_BLT;
          3'b101: branch_sel = kBR_BGE;
          3'b110: branch_sel = kBR_BLTU;
          3'b111: branch_sel = kBR_BGEU;
          default: begin
            illegal = 1'b1;
            op_sel  = kSAIL_ALUCTL_6to0_ILLEGAL;
          end
        endcase
      end
      kRV32I_OPCODE_IMMOP: begin
        if (funct3 == 3'b001) begin
          if (funct7 == kRV32I_FUNCT7_BASE) begin
            op_sel  = kSAIL_ALUCTL_6to0_SLL;
            illegal = 1'b0;
          end
        end else if (funct3 == 3'b101) begin
          if (funct7 == kRV32I_FUNCT7_BASE) begin
            op_sel  = kSAIL_ALUCTL_6to0_SRL;
            illegal = 1'b0;
          end else if (funct7 == kRV32I_FUNCT7_ALT) begin
            op_sel  = kSAIL_ALUCTL_6to0_SRA;
            illegal = 1'b0;
          end
        end else begin
          // funct7 bits are immediate bits here, so there is no SUB form
          op_sel  = base_op(funct3);
          illegal = 1'b0;
        end
      end
      kRV32I_OPCODE_ALUOP: begin
        if (funct7 == kRV32I_FUNCT7_BASE) begin
          op_sel  = base_op(funct3);
          illegal = 1'b0;
        end else if (funct7 == kRV32I_FUNCT7_ALT) begin
          if (funct3 == 3'b000) begin
            op_sel  = kSAIL_ALUCTL_6to0_SUB;
            illegal = 1'b0;
          end else if (funct3 == 3'b101) begin
            op_sel  = kSAIL_ALUCTL_6to0_SRA;
            illegal = 1'b0;
          end
        end else if ((funct7 == kRV32I_FUNCT7_MEXT) && (ENABLE_M != 0)) begin
          op_sel  = m_op(funct3);
          illegal = 1'b0;
          is_mul  = ~funct3[2];
          is_div  = funct3[2];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_control_pipe.sv
// Registered, valid/ready ALU control stage between decode and execute.
// Single-cycle ops are held one cycle after accept; RV32M ops wait out a
// parametrised latency first. Illegal decodes are counted (saturating).
module alu_control_pipe
  import alu_control_pipe_pkg::*;
#(
  parameter int ENABLE_M      = 1,
  parameter int MUL_LATENCY   = 2,
  parameter int DIV_LATENCY   = 33,
  parameter int ILL_CNT_WIDTH = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [6:0]                       opcode_i,
  input  logic [2:0]                       funct3_i,
  input  logic [6:0]                       funct7_i,
  input  logic                             flush_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [kALU_OP_SEL_WIDTH-1:0]     alu_op_sel_o,
  output logic [kALU_BRANCH_SEL_WIDTH-1:0] alu_branch_sel_o,
  output logic                             illegal_o,
  output logic                             multicycle_o,
  output logic                             busy_o,
  output logic [ILL_CNT_WIDTH-1:0]         ill_cnt_o
);

  // Countdown reload values: MC_WAIT lasts LAT-1 cycles
  localparam logic [7:0] kMUL_CNT = 8'(MUL_LATENCY - 1);
  localparam logic [7:0] kDIV_CNT = 8'(DIV_LATENCY - 1);

  state_e state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       accept;
  logic       load;

  logic [kALU_OP_SEL_WIDTH-1:0]     dec_op_sel;
  logic [kALU_BRANCH_SEL_WIDTH-1:0] dec_branch_sel;
  logic                             dec_illegal;
  logic                             dec_is_mul;
  logic                             dec_is_div;
  logic [7:0]                       lat_cnt;

  logic [kALU_OP_SEL_WIDTH-1:0]     op_sel_p1;
  logic [kALU_BRANCH_SEL_WIDTH-1:0] branch_sel_p1;
  logic                             illegal_p1;
  logic                             multicycle_p1;
  logic [ILL_CNT_WIDTH-1:0]         ill_cnt;

  alu_decode_comb #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .opcode     (opcode_i),
    .funct3     (funct3_i),
    .funct7     (funct7_i),
    .op_sel     (dec_op_sel),
    .branch_sel (dec_branch_sel),
    .illegal    (dec_illegal),
    .is_mul     (dec_is_mul),
    .is_div     (dec_is_div)
  );

  assign ready_o = !reset_i && !flush_i &&
                   ((state == ST_IDLE) || ((state == ST_HOLD) && ready_i));
  assign accept  = valid_i && ready_o;
  assign lat_cnt = dec_is_div ? kDIV_CNT : kMUL_CNT;

  // Next-state and countdown logic; flush overrides everything but reset
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    if (flush_i) begin
      state_next = ST_IDLE;
      cnt_next   = 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) load = 1'b1;
        end
        ST_HOLD: begin
          if (ready_i) begin
            if (accept) load = 1'b1;
            else        state_next = ST_IDLE;
          end
        end
        ST_MC_WAIT: begin
          if (cnt <= 8'd1) begin
            state_next = ST_HOLD;
            cnt_next   = 8'd0;
          end else begin
            cnt_next = cnt - 8'd1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
      // A latency of 1 skips MC_WAIT entirely
      if (load) begin
        if ((dec_is_mul || dec_is_div) && (lat_cnt != 8'd0)) begin
          state_next = ST_MC_WAIT;
          cnt_next   = lat_cnt;
        end else begin
          state_next = ST_HOLD;
          cnt_next   = 8'd0;
        end
      end
    end
  end

  // FSM state and countdown register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // ---- stage p1: decoded result captured on accept ----
  // Result registers load only on accept so they stay stable while held
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_sel_p1     <= '0;
      branch_sel_p1 <= '0;
      illegal_p1    <= 1'b0;
      multicycle_p1 <= 1'b0;
    end else if (load) begin
      op_sel_p1     <= dec_op_sel;
      branch_sel_p1 <= dec_branch_sel;
      illegal_p1    <= dec_illegal;
      multicycle_p1 <= dec_is_mul || dec_is_div;
    end
  end

  // Saturating count of accepted illegal encodings
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ill_cnt <= '0;
    end else if (accept && dec_illegal && (ill_cnt != {ILL_CNT_WIDTH{1'b1}})) begin
      ill_cnt <= ill_cnt + 1'b1;
    end
  end

  assign valid_o          = (state == ST_HOLD);
  assign busy_o           = (state == ST_MC_WAIT);
  assign alu_op_sel_o     = op_sel_p1;
  assign alu_branch_sel_o = branch_sel_p1;
  assign illegal_o        = illegal_p1;
  assign multicycle_o     = multicycle_p1;
  assign ill_cnt_o        = ill_cnt;

endmodule

// File: doc/alu_control_pipe.md
Name: alu_control_pipe

Overview:
- Registered, handshaked successor to the combinational ALU control decoder.
- Sits between the decode and execute stages. Decodes opcode/funct3/funct7 into ALU op and branch selects, and flags illegal encodings.
- Optionally adds RV32M ops (MUL*/DIV*/REM*) and holds each one for a parametrised multi-cycle latency.
- Back-pressures decode through a valid/ready handshake and counts illegal decodes.

Parameters:
- ENABLE_M, 1: 1 = decode RV32M (funct7=0000001 on ALUOP); 0 = those encodings are illegal.
- MUL_LATENCY, 2: cycles from accept to valid_o for MUL/MULH/MULHSU/MULHU; legal range 1..255.
- DIV_LATENCY, 33: cycles from accept to valid_o for DIV/DIVU/REM/REMU; legal range 1..255.
- ILL_CNT_WIDTH, 8: width of the saturating illegal-decode counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- valid_i  in  1  upstream instruction fields valid.
- ready_o  out  1  block accepts fields this cycle.
- opcode_i  in  7  instruction[6:0].
- funct3_i  in  3  instruction[14:12].
- funct7_i  in  7  instruction[31:25].
- flush_i  in  1  discard held/in-flight op.
- valid_o  out  1  decoded result valid.
- ready_i  in  1  execute consumes result.
- alu_op_sel_o  out  kALU_OP_SEL_WIDTH  ALU op select.
- alu_branch_sel_o  out  kALU_BRANCH_SEL_WIDTH  branch comparator select.
- illegal_o  out  1  held result is an illegal encoding.
- multicycle_o  out  1  held result came from an M-extension op.
- busy_o  out  1  multi-cycle countdown in progress.
- ill_cnt_o  out  ILL_CNT_WIDTH  saturating count of illegal decodes accepted.

Behaviour:
- FSM states: IDLE, HOLD, MC_WAIT.
- Reset (reset_i=1 at posedge) forces:
  - state=IDLE, counter=0, ill_cnt_o=0;
  - valid_o=0, busy_o=0, illegal_o=0, multicycle_o=0;
  - alu_op_sel_o=0, alu_branch_sel_o=0.
  - Reset mid-MC_WAIT abandons the op. ready_o=0 during the reset cycle.
- ready_o (combinational) = !reset_i && !flush_i && (state==IDLE || (state==HOLD && ready_i)).
- Accept = valid_i && ready_o. Decode occurs on the accept cycle and registers at the clock edge.
  - Single-cycle op: next state HOLD, valid_o=1 the following cycle (latency 1).
  - M op: next state MC_WAIT, count = LAT-1 (LAT = MUL_LATENCY or DIV_LATENCY), outputs already registered, valid_o=0, busy_o=1.
- MC_WAIT:
  - Decrements each cycle; at count==0 moves to HOLD, so valid_o rises exactly LAT cycles after the accept edge.
  - LAT=1 goes straight to HOLD, with no MC_WAIT cycle.
- HOLD:
  - Outputs stable while valid_o && !ready_i.
  - On ready_i: with a simultaneous accept, load the new result (back-to-back, no bubble); else go to IDLE with valid_o=0.
- flush_i:
  - Highest priority after reset: next state IDLE, valid_o=0, busy_o=0, count=0.
  - valid_i is ignored that cycle. ill_cnt_o is unchanged.
- Decode table is the existing RV32I table, unchanged:
  - LUI→AND; AUIPC/LOAD/STORE→ADD.
  - BRANCH→BRANCH plus branch select by funct3.
  - IMMOP/ALUOP by funct3, with funct7 bit5 choosing SUB/SRA.
  - JAL/JALR→ILLEGAL select, but these are legal: illegal_o=0.
- New legality rules:
  - ALUOP with funct7 ∉ {0000000, 0100000, 0000001} is illegal.
  - 0100000 is legal only with funct3 000/101.
  - SLLI with funct7≠0 is illegal; SRLI/SRAI with funct7 ∉ {0000000, 0100000} is illegal.
  - funct7=0000001 selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU by funct3 when ENABLE_M=1; illegal when ENABLE_M=0.
  - Invalid branch/load/store funct3 and unknown opcodes are illegal.
- Illegal result handling:
  - alu_op_sel_o=ILLEGAL, alu_branch_sel_o=0, illegal_o=1, single-cycle path.
  - ill_cnt_o increments on accept and saturates at all-ones.

Decomposition:
- Shared package/defines gain:
  - ALU select codes kSAIL_ALUCTL_6to0_MUL, _MULH, _MULHSU, _MULHU, _DIV, _DIVU, _REM, _REMU;
  - kRV32I_FUNCT7_BASE/ALT/MEXT;
  - FSM state encoding.
- One sub-module: alu_decode_comb, the pure combinational decoder that outputs op_sel, branch_sel, illegal, is_mul, is_div.
- alu_control_pipe holds the FSM, counter, registers and saturating counter.

Test Plan:
- Reset then ADD (opcode 0110011, f3 000, f7 0000000), valid_i=1, ready_i=1 → valid_o at cycle+1, alu_op_sel_o=ADD, illegal_o=0; back-to-back SUB (f7 0100000) next cycle with no bubble.
- DIV (f7 0000001, f3 100), DIV_LATENCY=33 → busy_o=1 and ready_o=0 for 32 cycles; valid_o rises 33 cycles after accept; multicycle_o=1.
- Same DIV with ENABLE_M=0 → valid_o at cycle+1, illegal_o=1, alu_op_sel_o=ILLEGAL, ill_cnt_o 0→1.
- BEQ accepted with ready_i=0 held 5 cycles → outputs stable and ready_o=0; on ready_i=1, drains then returns to IDLE.
- flush_i at MC_WAIT cycle 10 of a MUL (MUL_LATENCY=20) → next cycle valid_o=0, busy_o=0, ready_o=1; no stale result appears afterwards.
- 300 illegal opcodes (0000000) with ILL_CNT_WIDTH=8 → ill_cnt_o saturates at 255; reset_i mid-stream returns it to 0.
